// File: rtl/conf_int_add_pkg.sv
// Shared definitions for the configurable integer adder operand stage.
//   state_t              : skid-buffer occupancy encoding
//   ST_EMPTY/ONE/FULL    : occupancy states
//   RND_TRUNC/HALF_UP    : operand reduction modes
package conf_int_add_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

  localparam int unsigned RND_TRUNC   = 0;
  localparam int unsigned RND_HALF_UP = 1;

endpackage

// File: rtl/conf_int_add__opnd_prep.sv
// Combinational reduction of one operand to OP_BITWIDTH MSB-aligned bits.
//   x : raw operand
//   y : prepared operand, low DATA_PATH_BITWIDTH-OP_BITWIDTH bits zero
// With RND_HALF_UP the half-LSB is added first; the sum wraps modulo 2^DATA_PATH_BITWIDTH.
module conf_int_add__opnd_prep
  import conf_int_add_pkg::*;
#(
  parameter int unsigned OP_BITWIDTH        = 16,
  parameter int unsigned DATA_PATH_BITWIDTH = 16,
  parameter int unsigned RND_MODE           = RND_TRUNC
) (
  input  logic [DATA_PATH_BITWIDTH-1:0] x,
  output logic [DATA_PATH_BITWIDTH-1:0] y
);

  localparam int unsigned L = DATA_PATH_BITWIDTH - OP_BITWIDTH;

  if (L == 0) begin : g_pass
    assign y = x;
  end else begin : g_reduce
    localparam logic [DATA_PATH_BITWIDTH-1:0] One  = 1;
    localparam logic [DATA_PATH_BITWIDTH-1:0] Half = One << (L - 1);
    localparam logic [DATA_PATH_BITWIDTH-1:0] Mask = ~((One << L) - One);

    logic [DATA_PATH_BITWIDTH-1:0] sum;

    if (RND_MODE == RND_HALF_UP) begin : g_round
      assign sum = x + Half;
    end else begin : g_trunc
      assign sum = x;
    end

    assign y = sum & Mask;
  end

endmodule

// File: rtl/conf_int_add__opnd_stage.sv
// Registered operand-preparation stage in front of the configurable integer adder.
//   clk, rst            : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_a/in_b raw operands
//   out_valid/out_ready : downstream handshake, a/b prepared operands
//   pair_cnt            : wrapping count of delivered pairs
// Operands are prepared before storage; a two-entry skid buffer (main + skid slot)
// keeps in_ready free of any combinational path from out_ready.
module conf_int_add__opnd_stage
  import conf_int_add_pkg::*;
#(
  parameter int unsigned OP_BITWIDTH        = 16,
  parameter int unsigned DATA_PATH_BITWIDTH = 16,
  parameter int unsigned RND_MODE           = RND_TRUNC,
  parameter int unsigned CNT_BITWIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] a,
  output logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic [CNT_BITWIDTH-1:0]       pair_cnt
);

  localparam int unsigned W = DATA_PATH_BITWIDTH;

  state_t                  state_q, state_d;
  logic [W-1:0]            main_a_q, main_a_d, main_b_q, main_b_d;
  logic [W-1:0]            skid_a_q, skid_a_d, skid_b_q, skid_b_d;
  logic [CNT_BITWIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]            prep_a, prep_b;
  logic                    accept, consume;

  conf_int_add__opnd_prep #(
    .OP_BITWIDTH        (OP_BITWIDTH),
    .DATA_PATH_BITWIDTH (DATA_PATH_BITWIDTH),
    .RND_MODE           (RND_MODE)
  ) u_prep_a (
    .x (in_a),
    .y (prep_a)
  );

  conf_int_add__opnd_prep #(
    .OP_BITWIDTH        (OP_BITWIDTH),
    .DATA_PATH_BITWIDTH (DATA_PATH_BITWIDTH),
    .RND_MODE           (RND_MODE)
  ) u_prep_b (
    .x (in_b),
    .y (prep_b)
  );

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      main_a_q <= '0;
      main_b_q <= '0;
      skid_a_q <= '0;
      skid_b_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      main_a_q <= main_a_d;
      main_b_q <= main_b_d;
      skid_a_q <= skid_a_d;
      skid_b_q <= skid_b_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and slot updates
  always_comb begin
    state_d  = state_q;
    main_a_d = main_a_q;
    main_b_d = main_b_q;
    skid_a_d = skid_a_q;
    skid_b_d = skid_b_q;
    cnt_d    = cnt_q + CNT_BITWIDTH'(consume);
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d  = ST_ONE;
          main_a_d = prep_a;
          main_b_d = prep_b;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          main_a_d = prep_a;
          main_b_d = prep_b;
        end else if (accept) begin
          state_d  = ST_FULL;
          skid_a_d = prep_a;
          skid_b_d = prep_b;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (consume) begin
          state_d  = ST_ONE;
          main_a_d = skid_a_q;
          main_b_d = skid_b_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Outputs: pure decode of registered state; rst gates in_ready low during reset
  always_comb begin
    in_ready  = rst && (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY);
    a         = main_a_q;
    b         = main_b_q;
    pair_cnt  = cnt_q;
  end

endmodule
